// File: rtl/alu_driver.sv
// alu_driver: issues the nine ALU opcodes in turn over a valid/ready request,
// checks each response against an internal golden model and shows it on active-low LEDs.
module alu_driver #(
  parameter int unsigned DELAY_COUNT = 32'd50_000_000,
  parameter int unsigned TIMEOUT     = 32'd255,
  parameter logic [2:0]  A_INIT      = 3'b101,
  parameter logic [2:0]  B_INIT      = 3'b001
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       req_valid,
  input  logic       req_ready,
  output logic [3:0] req_op,
  output logic [2:0] req_a,
  output logic [2:0] req_b,
  input  logic       rsp_valid,
  input  logic [2:0] rsp_data,
  output logic [2:0] led,
  output logic       err,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_RSP  = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;

  // Reference result, 3-bit wrap-around; shifts of 3 or more clear the value.
  function automatic logic [2:0] golden(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b);
    logic [2:0] r;
    r = 3'b000;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SLL:  r = (b >= 3'd3) ? 3'b000 : (a << b);
      OP_XOR:  r = a ^ b;
      OP_SRL:  r = (b >= 3'd3) ? 3'b000 : (a >> b);
      OP_SLT:  r = ($signed(a) < $signed(b)) ? 3'b001 : 3'b000;
      OP_SLTU: r = (a < b) ? 3'b001 : 3'b000;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  state_t      state_r, state_s;
  logic [3:0]  op_r, op_s;
  logic        req_valid_r, req_valid_s;
  logic [2:0]  a_r, b_r;
  logic [2:0]  led_r, led_s;
  logic        err_r, err_s;
  logic [7:0]  err_cnt_r, err_cnt_s;
  logic [31:0] show_cnt_r, show_cnt_s;
  logic [31:0] wait_cnt_r, wait_cnt_s;
  logic [2:0]  gold_s;
  logic [2:0]  shown_s;
  logic        done_s;
  logic        bad_s;

  assign gold_s = golden(op_r, a_r, b_r);

  // Next-state and next-output logic for the request/response/show sequence.
  always_comb begin
    state_s     = state_r;
    op_s        = op_r;
    req_valid_s = req_valid_r;
    led_s       = led_r;
    err_s       = err_r;
    err_cnt_s   = err_cnt_r;
    show_cnt_s  = show_cnt_r;
    wait_cnt_s  = wait_cnt_r;
    shown_s     = 3'b111;
    done_s      = 1'b0;
    bad_s       = 1'b0;
    case (state_r)
      ST_REQ: begin
        if (!req_valid_r) begin
          req_valid_s = 1'b1;
        end else if (req_ready) begin
          req_valid_s = 1'b0;
          wait_cnt_s  = 32'd0;
          state_s     = ST_RSP;
        end else begin
          req_valid_s = 1'b1;
        end
      end
      ST_RSP: begin
        // A timeout is scored like a wrong answer and shown as all-ones.
        if (rsp_valid) begin
          done_s  = 1'b1;
          shown_s = rsp_data;
          bad_s   = (rsp_data != gold_s);
        end else if (wait_cnt_r == (TIMEOUT - 32'd1)) begin
          done_s  = 1'b1;
          shown_s = 3'b111;
          bad_s   = 1'b1;
        end else begin
          wait_cnt_s = wait_cnt_r + 32'd1;
        end
        if (done_s) begin
          led_s      = ~shown_s;
          show_cnt_s = 32'd0;
          wait_cnt_s = 32'd0;
          state_s    = ST_SHOW;
          if (bad_s) begin
            err_s     = 1'b1;
            err_cnt_s = (err_cnt_r == 8'd255) ? err_cnt_r : (err_cnt_r + 8'd1);
          end else begin
            err_s = err_r;
          end
        end else begin
          state_s = ST_RSP;
        end
      end
      ST_SHOW: begin
        if (show_cnt_r == (DELAY_COUNT - 32'd1)) begin
          show_cnt_s  = 32'd0;
          state_s     = ST_REQ;
          req_valid_s = 1'b1;
          op_s        = (op_r == OP_SLTU) ? OP_ADD : (op_r + 4'd1);
        end else begin
          show_cnt_s = show_cnt_r + 32'd1;
        end
      end
      default: begin
        state_s     = ST_REQ;
        op_s        = OP_ADD;
        req_valid_s = 1'b0;
        show_cnt_s  = 32'd0;
        wait_cnt_s  = 32'd0;
      end
    endcase
  end

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_REQ;
      op_r        <= OP_ADD;
      req_valid_r <= 1'b0;
      a_r         <= A_INIT;
      b_r         <= B_INIT;
      led_r       <= 3'b111;
      err_r       <= 1'b0;
      err_cnt_r   <= 8'd0;
      show_cnt_r  <= 32'd0;
      wait_cnt_r  <= 32'd0;
    end else begin
      state_r     <= state_s;
      op_r        <= op_s;
      req_valid_r <= req_valid_s;
      a_r         <= A_INIT;
      b_r         <= B_INIT;
      led_r       <= led_s;
      err_r       <= err_s;
      err_cnt_r   <= err_cnt_s;
      show_cnt_r  <= show_cnt_s;
      wait_cnt_r  <= wait_cnt_s;
    end
  end

  assign req_valid = req_valid_r;
  assign req_op    = op_r;
  assign req_a     = a_r;
  assign req_b     = b_r;
  assign led       = led_r;
  assign err       = err_r;
  assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_alu_driver.sv
// Scoreboard bench for alu_driver: a directed ALU responder plus a monitor that
// checks every request and the displayed result of each finished op.
module tb_alu_driver;
  localparam int unsigned DC = 4;
  localparam int unsigned TO = 8;

  localparam int M_OK    = 0;
  localparam int M_ADD0  = 1;
  localparam int M_NONE  = 2;
  localparam int M_BAD   = 3;
  localparam int M_EARLY = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_op;
  logic [2:0] req_a;
  logic [2:0] req_b;
  logic       rsp_valid;
  logic [2:0] rsp_data;
  logic [2:0] led;
  logic       err;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  alu_driver #(.DELAY_COUNT(DC), .TIMEOUT(TO), .A_INIT(3'b101), .B_INIT(3'b001)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .led(led), .err(err), .err_cnt(err_cnt)
  );

  typedef struct { logic [3:0] op; logic [2:0] led; logic err; logic [7:0] cnt; int gap; } exp_t;
  typedef struct { int mode; int stall; } stim_t;

  exp_t  exp_q[$];
  stim_t stim_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  logic  pending = 1'b0;

  // Hand-computed results for a=5, b=1.
  function automatic logic [2:0] gold_of(input logic [3:0] op);
    case (op)
      4'd0: return 3'd6;
      4'd1: return 3'd4;
      4'd2: return 3'd1;
      4'd3: return 3'd5;
      4'd4: return 3'd2;
      4'd5: return 3'd4;
      4'd6: return 3'd2;
      4'd7: return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] led_of(input int op);
    case (op)
      0: return 3'b001;
      1: return 3'b011;
      2: return 3'b110;
      3: return 3'b010;
      4: return 3'b101;
      5: return 3'b011;
      6: return 3'b101;
      7: return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input int op, input int mode, input int stall,
                      input logic [2:0] led_e, input logic err_e, input int cnt_e, input int gap_e);
    exp_t  e;
    stim_t s;
    e.op = op[3:0]; e.led = led_e; e.err = err_e; e.cnt = cnt_e[7:0]; e.gap = gap_e;
    s.mode = mode; s.stall = stall;
    exp_q.push_back(e);
    stim_q.push_back(s);
  endtask

  // ALU responder: drives inputs on the falling edge.
  stim_t      cur;
  logic       loaded = 1'b0;
  logic       resp_due = 1'b0;
  logic [3:0] resp_op = 4'd0;
  int         stall = 0;
  initial begin
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 3'b000;
    cur.mode = M_OK; cur.stall = 0;
    forever begin
      @(negedge clk);
      rsp_valid = 1'b0;
      rsp_data  = 3'b000;
      if (!rst_n) begin
        loaded = 1'b0; resp_due = 1'b0; req_ready = 1'b0; stall = 0;
      end else begin
        if (resp_due) begin
          resp_due = 1'b0;
          case (cur.mode)
            M_OK, M_EARLY: begin rsp_valid = 1'b1; rsp_data = gold_of(resp_op); end
            M_ADD0: begin rsp_valid = 1'b1; rsp_data = (resp_op == 4'd0) ? 3'b000 : gold_of(resp_op); end
            M_BAD: begin rsp_valid = 1'b1; rsp_data = ~gold_of(resp_op); end
            default: rsp_valid = 1'b0;
          endcase
        end
        if (req_valid && !loaded && stim_q.size() > 0) begin
          cur = stim_q.pop_front();
          loaded = 1'b1;
          stall = cur.stall;
        end
        req_ready = loaded && (stall == 0);
        if (loaded && stall > 0) stall--;
        if (req_valid && req_ready) begin
          resp_due = 1'b1;
          resp_op  = req_op;
          loaded   = 1'b0;
          if (cur.mode == M_EARLY) begin
            rsp_valid = 1'b1;
            rsp_data  = ~gold_of(req_op);
          end
        end
      end
    end
  end

  // Monitor: pops an expectation at each handshake, checks its result when REQ re-opens.
  exp_t       pend;
  int         since = 0;
  logic       hs;
  logic       prev_valid = 1'b0;
  logic       prev_hs = 1'b0;
  logic [3:0] prev_op = 4'd0;
  logic [2:0] prev_a = 3'd0;
  logic [2:0] prev_b = 3'd0;
  initial begin
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        pending = 1'b0; prev_valid = 1'b0; prev_hs = 1'b0; since = 0;
      end else begin
        since++;
        hs = req_valid && req_ready;
        if (req_valid && !prev_valid && pending) begin
          check("led", {29'd0, led}, {29'd0, pend.led});
          check("err", {31'd0, err}, {31'd0, pend.err});
          check("err_cnt", {24'd0, err_cnt}, {24'd0, pend.cnt});
          check("period", since, pend.gap);
          pending = 1'b0;
        end
        if (req_valid && prev_valid && !prev_hs) begin
          check("stall_op", {28'd0, req_op}, {28'd0, prev_op});
          check("stall_a", {29'd0, req_a}, {29'd0, prev_a});
          check("stall_b", {29'd0, req_b}, {29'd0, prev_b});
        end
        if (hs) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL extra_handshake: got op %0d, expected no request", req_op);
          end else begin
            pend = exp_q.pop_front();
            check("req_op", {28'd0, req_op}, {28'd0, pend.op});
            check("req_a", {29'd0, req_a}, 32'd5);
            check("req_b", {29'd0, req_b}, 32'd1);
            pending = 1'b1;
            since = 0;
          end
        end
        prev_valid = req_valid; prev_hs = hs;
        prev_op = req_op; prev_a = req_a; prev_b = req_b;
      end
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, "_valid"}, {31'd0, req_valid}, 32'd0);
    check({tag, "_op"}, {28'd0, req_op}, 32'd0);
    check({tag, "_led"}, {29'd0, led}, 32'd7);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_cnt"}, {24'd0, err_cnt}, 32'd0);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && (exp_q.size() != 0 || pending); i++) @(posedge clk);
    #1;
    if (exp_q.size() != 0 || pending) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: got %0d entries left, expected 0", tag, exp_q.size());
    end
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");

    for (int op = 0; op < 9; op++) push(op, M_OK, 0, led_of(op), 1'b0, 0, 6);
    push(0, M_ADD0, 0, 3'b111, 1'b1, 1, 6);
    push(1, M_OK, 0, led_of(1), 1'b1, 1, 6);
    push(2, M_OK, 10, led_of(2), 1'b1, 1, 6);
    push(3, M_EARLY, 0, led_of(3), 1'b1, 1, 6);
    push(4, M_NONE, 0, 3'b000, 1'b1, 2, 13);
    push(5, M_NONE, 0, 3'b000, 1'b1, 3, 13);
    for (int op = 6; op < 12; op++) push(op % 9, M_OK, 0, led_of(op % 9), 1'b1, 3, 6);
    push(3, M_NONE, 0, 3'b000, 1'b1, 4, 13);

    rst_n = 1'b1;
    #1;
    check("valid_pre_edge", {31'd0, req_valid}, 32'd0);
    @(posedge clk); #1;
    check("valid_first_edge", {31'd0, req_valid}, 32'd1);

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check("abort_in_rsp", {31'd0, req_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    reset_checks("midreset");
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    stim_q.delete();

    for (int i = 0; i < 300; i++) begin
      cnt = (i + 1 > 255) ? 255 : i + 1;
      push(i % 9, M_BAD, 0, gold_of(4'(i % 9)), 1'b1, cnt, 6);
    end
    push(3, M_OK, 0, led_of(3), 1'b1, 255, 6);
    push(4, M_OK, 0, led_of(4), 1'b1, 255, 6);
    rst_n = 1'b1;
    wait_drain("saturate", 4000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_driver.md
ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 Parameters, one per line, SHALL be:
- DELAY_COUNT, 50_000_000, SHOW dwell in clk cycles (>=1).
- TIMEOUT, 255, max RSP wait in clk cycles (>=1).
- A_INIT, 3'b101, operand a.
- B_INIT, 3'b001, operand b.

REQ-002 Ports, one per line, SHALL be:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  out  1  request valid to the ALU.
- req_ready  in  1  ALU accepts the request.
- req_op  out  4  opcode.
- req_a  out  3  operand a.
- req_b  out  3  operand b.
- rsp_valid  in  1  ALU result valid.
- rsp_data  in  3  ALU result.
- led  out  3  active-low result display.
- err  out  1  sticky mismatch/timeout flag.
- err_cnt  out  8  saturating error count.

Function
REQ-003 Opcodes SHALL be ADD=0, SUB=1, AND=2, OR=3, SLL=4, XOR=5, SRL=6, SLT=7, SLTU=8; 9..15 are never issued.
REQ-004 The op index SHALL advance 0..8 and wrap from 8 to 0.
REQ-005 FSM states SHALL be REQ, RSP, SHOW; after reset it enters REQ with op=ADD.
REQ-006 REQ: req_valid=1, req_op/req_a/req_b stable until handshake; handshake = req_valid&req_ready on a posedge -> RSP next cycle, req_valid=0.
REQ-007 RSP: first cycle with rsp_valid=1 captures rsp_data -> SHOW next cycle; rsp_valid outside RSP is ignored.
REQ-008 RSP timeout: TIMEOUT cycles in RSP without rsp_valid -> treated as error, displayed result forced 3'b111 (led=3'b000), -> SHOW.
REQ-009 Golden model, 3-bit, wrap modulo 8:
- ADD a+b; SUB a-b; AND, OR, XOR bitwise.
- SLL a<<b[2:0], SRL a>>b[2:0] logical; shift >=3 gives 0.
- SLT signed 3-bit compare; SLTU unsigned compare; both give 3'b001 or 3'b000.
REQ-010 Captured result != golden, or timeout -> err set, err_cnt +1 saturating at 255; evaluated once per op, on the RSP exit cycle.
REQ-011 led SHALL update on the RSP exit cycle to ~captured result and hold through SHOW and the next REQ/RSP.
REQ-012 SHOW SHALL last exactly DELAY_COUNT cycles (internal 32-bit counter), then -> REQ with next op.
REQ-013 req_ready held high in every cycle SHALL give a sustained handshake period of DELAY_COUNT+2 cycles per op plus ALU response latency.
REQ-014 req_ready=1 and rsp_valid=1 in the same REQ cycle: handshake taken, rsp ignored, driver still waits in RSP.

Reset
REQ-015 rst_n low SHALL asynchronously force: state=REQ, op=ADD, req_valid=0, led=3'b111, err=0, err_cnt=0, counters=0.
REQ-016 req_valid SHALL first assert on the first posedge after rst_n deasserts.
REQ-017 Reset mid-transaction SHALL abandon that op with no err/err_cnt update.

Verification (DELAY_COUNT=4, TIMEOUT=8, a=5, b=1)
REQ-018 Correct responder, 1-cycle latency, 9 ops -> led sequence:
- 001 (ADD 6), 011 (SUB 4), 110 (AND 1), 010 (OR 5), 101 (SLL 2)
- 011 (XOR 4), 101 (SRL 2), 110 (SLT 1), 111 (SLTU 0)
- then req_op=0 again; err=0.
REQ-019 Responder returns 0 for ADD -> led=111, err=1, err_cnt=1; sequence continues to SUB.
REQ-020 rsp_valid never asserted -> exactly 8 cycles in RSP, led=000, err_cnt increments once per op.
REQ-021 req_ready low for 10 cycles -> req_valid/req_op/req_a/req_b stable all 10 cycles; no op skipped.
REQ-022 rst_n pulsed low during RSP of OR -> all outputs at reset values immediately; restart at ADD; err_cnt=0.
REQ-023 Forced 300 mismatches -> err_cnt saturates at 255 and stays there.
